// File: rtl/sha3_round_sequencer.sv
// Iterative Keccak-f controller: owns the 5x5x64 state and drives an
// external round datapath once per round, then holds the result for handoff.
module sha3_round_sequencer #(
   parameter int ROUNDS   = 24,
   parameter int WATCHDOG = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] isa [5],
   input  logic [63:0] isb [5],
   input  logic [63:0] isc [5],
   input  logic [63:0] isd [5],
   input  logic [63:0] ise [5],
   input  logic        start,
   output logic        iready,
   output logic [63:0] rsa [5],
   output logic [63:0] rsb [5],
   output logic [63:0] rsc [5],
   output logic [63:0] rsd [5],
   output logic [63:0] rse [5],
   output logic [4:0]  rround,
   output logic        rsample,
   input  logic [63:0] risa [5],
   input  logic [63:0] risb [5],
   input  logic [63:0] risc [5],
   input  logic [63:0] risd [5],
   input  logic [63:0] rise [5],
   input  logic        rgood,
   output logic        ogood,
   output logic [63:0] osa [5],
   output logic [63:0] osb [5],
   output logic [63:0] osc [5],
   output logic [63:0] osd [5],
   output logic [63:0] ose [5],
   input  logic        oack,
   output logic        oerror
);

   localparam int WW = (WATCHDOG > 1) ? $clog2(WATCHDOG) : 1;
   localparam logic [4:0] LAST = 5'(ROUNDS - 1);
   localparam logic [WW-1:0] WLAST = WW'(WATCHDOG - 1);

   if (ROUNDS < 1 || ROUNDS > 32) begin : g_bad_rounds
      $error("ROUNDS must be in 1..32");
   end
   if (WATCHDOG < 1) begin : g_bad_wdog
      $error("WATCHDOG must be >= 1");
   end

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE,
      ERROR
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [4:0]    round_q;
   logic [4:0]    round_d;
   logic [WW-1:0] wdog_q;
   logic [WW-1:0] wdog_d;
   logic          ld_in;
   logic          ld_res;

   // st[y][x]: row y maps to the a..e port suffix, x to the array index
   logic [63:0] st  [5][5];
   logic [63:0] ins [5][5];
   logic [63:0] ris [5][5];

   always_comb begin
      for (int x = 0; x < 5; x++) begin
         ins[0][x] = isa[x];
         ins[1][x] = isb[x];
         ins[2][x] = isc[x];
         ins[3][x] = isd[x];
         ins[4][x] = ise[x];
         ris[0][x] = risa[x];
         ris[1][x] = risb[x];
         ris[2][x] = risc[x];
         ris[3][x] = risd[x];
         ris[4][x] = rise[x];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         round_q <= '0;
         wdog_q  <= '0;
         for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
               st[y][x] <= '0;
            end
         end
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         wdog_q  <= wdog_d;
         for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
               if (ld_in) begin
                  st[y][x] <= ins[y][x];
               end else if (ld_res) begin
                  st[y][x] <= ris[y][x];
               end
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      wdog_d  = wdog_q;
      ld_in   = 1'b0;
      ld_res  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               ld_in   = 1'b1;
               round_d = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            wdog_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // a result arriving on the last allowed cycle still wins
            if (rgood) begin
               ld_res = 1'b1;
               wdog_d = '0;
               if (round_q == LAST) begin
                  state_d = DONE;
               end else begin
                  round_d = round_q + 5'd1;
                  state_d = ISSUE;
               end
            end else if (wdog_q == WLAST) begin
               state_d = ERROR;
            end else begin
               wdog_d = wdog_q + WW'(1);
            end
         end
         DONE: begin
            if (oack) begin
               round_d = '0;
               state_d = IDLE;
            end
         end
         ERROR: begin
            state_d = ERROR;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      iready  = (state_q == IDLE);
      rsample = (state_q == ISSUE);
      ogood   = (state_q == DONE);
      oerror  = (state_q == ERROR);
      rround  = round_q;
   end

   always_comb begin
      for (int x = 0; x < 5; x++) begin
         rsa[x] = st[0][x];
         rsb[x] = st[1][x];
         rsc[x] = st[2][x];
         rsd[x] = st[3][x];
         rse[x] = st[4][x];
         osa[x] = st[0][x];
         osb[x] = st[1][x];
         osc[x] = st[2][x];
         osd[x] = st[3][x];
         ose[x] = st[4][x];
      end
   end

   a_round_range: assert property (
      @(posedge clk) disable iff (rst) round_q <= LAST
   );

endmodule

// File: doc/sha3_round_sequencer.md
Name: sha3_round_sequencer

Overview:
- Iterative Keccak-f controller; owns the 5x5x64 working state and sequences ROUNDS passes through an external round datapath.
- Accepts a state on a start strobe, then issues it to the round logic once per round with the round index.
- Captures each returned state and presents the final permutation result with a valid/ack handshake.
- Sits between the absorb/pad front end and the squeeze stage; the round logic may be combinational-plus-register or deeper-pipelined.

Parameters:
ROUNDS, 24, rounds per permutation; legal 1..32, otherwise $error
WATCHDOG, 8, max WAIT cycles allowed for a round result; legal >=1, otherwise $error

Ports:
clk  input  1  clock, single domain
rst  input  1  synchronous, active-high reset
isa,isb,isc,isd,ise  input  64 x[5] each  permutation input state rows
start  input  1  load input state; accepted only when iready=1
iready  output  1  block idle and able to accept start
rsa,rsb,rsc,rsd,rse  output  64 x[5] each  working state driven to round logic
rround  output  5  round index for the round constant, 0..ROUNDS-1
rsample  output  1  one-cycle strobe: round logic samples rs*/rround
risa,risb,risc,risd,rise  input  64 x[5] each  round logic result
rgood  input  1  round result valid, one cycle
ogood  output  1  final state valid, held until oack
osa,osb,osc,osd,ose  output  64 x[5] each  final state, stable while ogood=1
oack  input  1  consumer accepts the result
oerror  output  1  watchdog fault, sticky until rst

Behaviour:
- Use one FSM with states IDLE, ISSUE, WAIT, DONE and ERROR. Registers: st[5][5], round counter (5b) and wdog counter.
- Reset, on a clk edge with rst=1: FSM=IDLE, st=all 0, round=0, wdog=0.
- Outputs after reset: iready=1, rsample=0, ogood=0, oerror=0, rround=0, rs*/os*=0.
- rst has priority over every other input in every state.
- All outputs decode from registers. No input-to-output combinational path.
- rs*=st and os*=st at all times. rround=round.
- IDLE: iready=1.
  - start=1: st<=is*, round<=0, go to ISSUE.
  - rgood and oack are ignored.
- ISSUE: rsample=1 for exactly one cycle, wdog<=0, go to WAIT.
  - rgood in the ISSUE cycle is ignored; round logic latency L>=1.
- WAIT:
  - rgood=1: st<=ri*, wdog<=0.
    - If round==ROUNDS-1, go to DONE.
    - Otherwise round<=round+1 and go to ISSUE.
  - rgood=0 with wdog==WATCHDOG-1: go to ERROR.
  - rgood=0 otherwise: wdog<=wdog+1.
  - Net effect: a result with latency L is accepted iff L<=WATCHDOG.
- DONE: ogood=1, os* stable.
  - oack=1: go to IDLE, round<=0. iready=1 on the next cycle.
  - start is ignored in DONE (iready=0).
- ERROR: oerror=1, iready=0, ogood=0, rsample=0. Only rst exits ERROR.
- start while iready=0 is dropped, not queued.
- rgood outside WAIT is discarded and never alters st.
- Latency, with start accepted at edge 0 and round latency L:
  - round k rsample is high in cycle 1+k(L+1);
  - ogood first rises in cycle ROUNDS*(L+1)+1;
  - for ROUNDS=24, L=1: cycle 49.
- Throughput: one permutation per ROUNDS*(L+1)+2 cycles, counting the IDLE cycle after oack.
- Wrap: the round counter never exceeds ROUNDS-1. It returns to 0 on DONE->IDLE and on reset.

Test Plan:
- Reset check: rst high for 2 cycles, then low. Required: iready=1, ogood=0, oerror=0, rsample=0, os*=0.
- Known-answer test, L=1 with a reference round model, ROUNDS=24, all-zero input.
  - ogood rises at cycle 49.
  - osa[0]=64'hF1258F7940E1DDE7, osa[1]=64'h84D5CCF933C0478A.
  - rround sequence is 0..23, with exactly 24 rsample pulses.
- Variable latency L=8=WATCHDOG: completes, ogood at cycle 24*9+1=217, oerror=0.
- Watchdog, L=9:
  - oerror=1 at cycle 1+9=10 (WAIT cycles 2..9 hold no rgood);
  - ogood never rises, start ignored; rst clears oerror.
- Handshake:
  - hold oack=0 for 20 cycles after ogood: os* stable, ogood stays 1, start during DONE ignored;
  - oack=1: iready=1 next cycle;
  - back-to-back start then completes with correct new result.
- Spurious/mid-op events:
  - rgood pulses in IDLE, ISSUE and DONE: no state change;
  - rst asserted mid-WAIT at round 10: IDLE next cycle, round=0, st=0, a following start runs all 24 rounds.
